// File: rtl/trigger_pkg.sv
// Shared types and constants for the L1 trigger datapath.
// Contents: weight width/depth, the signed weight type and the
// weight content function used to define the coefficient store.
package trigger_pkg;

    localparam int WEIGHT_W     = 8;
    localparam int WEIGHT_DEPTH = 256;

    typedef logic signed [WEIGHT_W-1:0] weight_t;

    // Weight content: low byte of (a*37 + 11), reinterpreted as two's complement.
    function automatic weight_t weight_init(input logic [7:0] addr);
        logic [15:0] prod;
        prod = 16'(addr) * 16'd37 + 16'd11;
        return weight_t'(prod[7:0]);
    endfunction

endpackage

// File: rtl/weights_rom.sv
// Read-only store of 256 signed 8-bit coefficients, one read per clock.
// Ports: clk, rst (sync, active-high), addr (8-bit unsigned) in;
//        data (signed weight, registered, 1-cycle latency) out.
module weights_rom
    import trigger_pkg::*;
#(
    parameter int DEPTH = WEIGHT_DEPTH,
    parameter int WIDTH = WEIGHT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    output logic signed [WIDTH-1:0]    data
);

    weight_t rom_word;

    // Literal table so synthesis maps it to ROM/LUTs; entries follow weight_init().
    always_comb begin
        rom_word = '0;
        case (addr)
            8'd0:   rom_word = 8'h0B;
            8'd1:   rom_word = 8'h30;
            8'd2:   rom_word = 8'h55;
            8'd3:   rom_word = 8'h7A;
            8'd4:   rom_word = 8'h9F;
            8'd5:   rom_word = 8'hC4;
            8'd6:   rom_word = 8'hE9;
            8'd7:   rom_word = 8'h0E;
            8'd8:   rom_word = 8'h33;
            8'd9:   rom_word = 8'h58;
            8'd10:  rom_word = 8'h7D;
            8'd11:  rom_word = 8'hA2;
            8'd12:  rom_word = 8'hC7;
            8'd13:  rom_word = 8'hEC;
            8'd14:  rom_word = 8'h11;
            8'd15:  rom_word = 8'h36;
            8'd16:  rom_word = 8'h5B;
            8'd17:  rom_word = 8'h80;
            8'd18:  rom_word = 8'hA5;
            8'd19:  rom_word = 8'hCA;
            8'd20:  rom_word = 8'hEF;
            8'd21:  rom_word = 8'h14;
            8'd22:  rom_word = 8'h39;
            8'd23:  rom_word = 8'h5E;
            8'd24:  rom_word = 8'h83;
            8'd25:  rom_word = 8'hA8;
            8'd26:  rom_word = 8'hCD;
            8'd27:  rom_word = 8'hF2;
            8'd28:  rom_word = 8'h17;
            8'd29:  rom_word = 8'h3C;
            8'd30:  rom_word = 8'h61;
            8'd31:  rom_word = 8'h86;
            8'd32:  rom_word = 8'hAB;
            8'd33:  rom_word = 8'hD0;
            8'd34:  rom_word = 8'hF5;
            8'd35:  rom_word = 8'h1A;
            8'd36:  rom_word = 8'h3F;
            8'd37:  rom_word = 8'h64;
            8'd38:  rom_word = 8'h89;
            8'd39:  rom_word = 8'hAE;
            8'd40:  rom_word = 8'hD3;
            8'd41:  rom_word = 8'hF8;
            8'd42:  rom_word = 8'h1D;
            8'd43:  rom_word = 8'h42;
            8'd44:  rom_word = 8'h67;
            8'd45:  rom_word = 8'h8C;
            8'd46:  rom_word = 8'hB1;
            8'd47:  rom_word = 8'hD6;
            8'd48:  rom_word = 8'hFB;
            8'd49:  rom_word = 8'h20;
            8'd50:  rom_word = 8'h45;
            8'd51:  rom_word = 8'h6A;
            8'd52:  rom_word = 8'h8F;
            8'd53:  rom_word = 8'hB4;
            8'd54:  rom_word = 8'hD9;
            8'd55:  rom_word = 8'hFE;
            8'd56:  rom_word = 8'h23;
            8'd57:  rom_word = 8'h48;
            8'd58:  rom_word = 8'h6D;
            8'd59:  rom_word = 8'h92;
            8'd60:  rom_word = 8'hB7;
            8'd61:  rom_word = 8'hDC;
            8'd62:  rom_word = 8'h01;
            8'd63:  rom_word = 8'h26;
            8'd64:  rom_word = 8'h4B;
            8'd65:  rom_word = 8'h70;
            8'd66:  rom_word = 8'h95;
            8'd67:  rom_word = 8'hBA;
            8'd68:  rom_word = 8'hDF;
            8'd69:  rom_word = 8'h04;
            8'd70:  rom_word = 8'h29;
            8'd71:  rom_word = 8'h4E;
            8'd72:  rom_word = 8'h73;
            8'd73:  rom_word = 8'h98;
            8'd74:  rom_word = 8'hBD;
            8'd75:  rom_word = 8'hE2;
            8'd76:  rom_word = 8'h07;
            8'd77:  rom_word = 8'h2C;
            8'd78:  rom_word = 8'h51;
            8'd79:  rom_word = 8'h76;
            8'd80:  rom_word = 8'h9B;
            8'd81:  rom_word = 8'hC0;
            8'd82:  rom_word = 8'hE5;
            8'd83:  rom_word = 8'h0A;
            8'd84:  rom_word = 8'h2F;
            8'd85:  rom_word = 8'h54;
            8'd86:  rom_word = 8'h79;
            8'd87:  rom_word = 8'h9E;
            8'd88:  rom_word = 8'hC3;
            8'd89:  rom_word = 8'hE8;
            8'd90:  rom_word = 8'h0D;
            8'd91:  rom_word = 8'h32;
            8'd92:  rom_word = 8'h57;
            8'd93:  rom_word = 8'h7C;
            8'd94:  rom_word = 8'hA1;
            8'd95:  rom_word = 8'hC6;
            8'd96:  rom_word = 8'hEB;
            8'd97:  rom_word = 8'h10;
            8'd98:  rom_word = 8'h35;
            8'd99:  rom_word = 8'h5A;
            8'd100: rom_word = 8'h7F;
            8'd101: rom_word = 8'hA4;
            8'd102: rom_word = 8'hC9;
            8'd103: rom_word = 8'hEE;
            8'd104: rom_word = 8'h13;
            8'd105: rom_word = 8'h38;
            8'd106: rom_word = 8'h5D;
            8'd107: rom_word = 8'h82;
            8'd108: rom_word = 8'hA7;
            8'd109: rom_word = 8'hCC;
            8'd110: rom_word = 8'hF1;
            8'd111: rom_word = 8'h16;
            8'd112: rom_word = 8'h3B;
            8'd113: rom_word = 8'h60;
            8'd114: rom_word = 8'h85;
            8'd115: rom_word = 8'hAA;
            8'd116: rom_word = 8'hCF;
            8'd117: rom_word = 8'hF4;
            8'd118: rom_word = 8'h19;
            8'd119: rom_word = 8'h3E;
            8'd120: rom_word = 8'h63;
            8'd121: rom_word = 8'h88;
            8'd122: rom_word = 8'hAD;
            8'd123: rom_word = 8'hD2;
            8'd124: rom_word = 8'hF7;
            8'd125: rom_word = 8'h1C;
            8'd126: rom_word = 8'h41;
            8'd127: rom_word = 8'h66;
            8'd128: rom_word = 8'h8B;
            8'd129: rom_word = 8'hB0;
            8'd130: rom_word = 8'hD5;
            8'd131: rom_word = 8'hFA;
            8'd132: rom_word = 8'h1F;
            8'd133: rom_word = 8'h44;
            8'd134: rom_word = 8'h69;
            8'd135: rom_word = 8'h8E;
            8'd136: rom_word = 8'hB3;
            8'd137: rom_word = 8'hD8;
            8'd138: rom_word = 8'hFD;
            8'd139: rom_word = 8'h22;
            8'd140: rom_word = 8'h47;
            8'd141: rom_word = 8'h6C;
            8'd142: rom_word = 8'h91;
            8'd143: rom_word = 8'hB6;
            8'd144: rom_word = 8'hDB;
            8'd145: rom_word = 8'h00;
            8'd146: rom_word = 8'h25;
            8'd147: rom_word = 8'h4A;
            8'd148: rom_word = 8'h6F;
            8'd149: rom_word = 8'h94;
            8'd150: rom_word = 8'hB9;
            8'd151: rom_word = 8'hDE;
            8'd152: rom_word = 8'h03;
            8'd153: rom_word = 8'h28;
            8'd154: rom_word = 8'h4D;
            8'd155: rom_word = 8'h72;
            8'd156: rom_word = 8'h97;
            8'd157: rom_word = 8'hBC;
            8'd158: rom_word = 8'hE1;
            8'd159: rom_word = 8'h06;
            8'd160: rom_word = 8'h2B;
            8'd161: rom_word = 8'h50;
            8'd162: rom_word = 8'h75;
            8'd163: rom_word = 8'h9A;
            8'd164: rom_word = 8'hBF;
            8'd165: rom_word = 8'hE4;
            8'd166: rom_word = 8'h09;
            8'd167: rom_word = 8'h2E;
            8'd168: rom_word = 8'h53;
            8'd169: rom_word = 8'h78;
            8'd170: rom_word = 8'h9D;
            8'd171: rom_word = 8'hC2;
            8'd172: rom_word = 8'hE7;
            8'd173: rom_word = 8'h0C;
            8'd174: rom_word = 8'h31;
            8'd175: rom_word = 8'h56;
            8'd176: rom_word = 8'h7B;
            8'd177: rom_word = 8'hA0;
            8'd178: rom_word = 8'hC5;
            8'd179: rom_word = 8'hEA;
            8'd180: rom_word = 8'h0F;
            8'd181: rom_word = 8'h34;
            8'd182: rom_word = 8'h59;
            8'd183: rom_word = 8'h7E;
            8'd184: rom_word = 8'hA3;
            8'd185: rom_word = 8'hC8;
            8'd186: rom_word = 8'hED;
            8'd187: rom_word = 8'h12;
            8'd188: rom_word = 8'h37;
            8'd189: rom_word = 8'h5C;
            8'd190: rom_word = 8'h81;
            8'd191: rom_word = 8'hA6;
            8'd192: rom_word = 8'hCB;
            8'd193: rom_word = 8'hF0;
            8'd194: rom_word = 8'h15;
            8'd195: rom_word = 8'h3A;
            8'd196: rom_word = 8'h5F;
            8'd197: rom_word = 8'h84;
            8'd198: rom_word = 8'hA9;
            8'd199: rom_word = 8'hCE;
            8'd200: rom_word = 8'hF3;
            8'd201: rom_word = 8'h18;
            8'd202: rom_word = 8'h3D;
            8'd203: rom_word = 8'h62;
            8'd204: rom_word = 8'h87;
            8'd205: rom_word = 8'hAC;
            8'd206: rom_word = 8'hD1;
            8'd207: rom_word = 8'hF6;
            8'd208: rom_word = 8'h1B;
            8'd209: rom_word = 8'h40;
            8'd210: rom_word = 8'h65;
            8'd211: rom_word = 8'h8A;
            8'd212: rom_word = 8'hAF;
            8'd213: rom_word = 8'hD4;
            8'd214: rom_word = 8'hF9;
            8'd215: rom_word = 8'h1E;
            8'd216: rom_word = 8'h43;
            8'd217: rom_word = 8'h68;
            8'd218: rom_word = 8'h8D;
            8'd219: rom_word = 8'hB2;
            8'd220: rom_word = 8'hD7;
            8'd221: rom_word = 8'hFC;
            8'd222: rom_word = 8'h21;
            8'd223: rom_word = 8'h46;
            8'd224: rom_word = 8'h6B;
            8'd225: rom_word = 8'h90;
            8'd226: rom_word = 8'hB5;
            8'd227: rom_word = 8'hDA;
            8'd228: rom_word = 8'hFF;
            8'd229: rom_word = 8'h24;
            8'd230: rom_word = 8'h49;
            8'd231: rom_word = 8'h6E;
            8'd232: rom_word = 8'h93;
            8'd233: rom_word = 8'hB8;
            8'd234: rom_word = 8'hDD;
            8'd235: rom_word = 8'h02;
            8'd236: rom_word = 8'h27;
            8'd237: rom_word = 8'h4C;
            8'd238: rom_word = 8'h71;
            8'd239: rom_word = 8'h96;
            8'd240: rom_word = 8'hBB;
            8'd241: rom_word = 8'hE0;
            8'd242: rom_word = 8'h05;
            8'd243: rom_word = 8'h2A;
            8'd244: rom_word = 8'h4F;
            8'd245: rom_word = 8'h74;
            8'd246: rom_word = 8'h99;
            8'd247: rom_word = 8'hBE;
            8'd248: rom_word = 8'hE3;
            8'd249: rom_word = 8'h08;
            8'd250: rom_word = 8'h2D;
            8'd251: rom_word = 8'h52;
            8'd252: rom_word = 8'h77;
            8'd253: rom_word = 8'h9C;
            8'd254: rom_word = 8'hC1;
            8'd255: rom_word = 8'hE6;
            default: rom_word = '0;
        endcase
    end

    // Output register: reset wins over the address so no stale weight survives it.
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else begin
            data <= rom_word;
        end
    end

endmodule

// File: tb/tb_weights_rom.sv
// Bench for weights_rom: directed phases (reset, sequential, sign, sweep with
// mid-stream reset, hold) followed by random addresses with sporadic resets.
// A scoreboard queue receives expected weights at each edge; a monitor checks them.
module tb_weights_rom;

    logic              clk;
    logic              rst;
    logic [7:0]        addr;
    logic signed [7:0] data;

    typedef struct {
        int exp_val;
        int addr_tag;
        bit rst_tag;
    } exp_t;

    exp_t exp_q[$];
    bit   active;
    int   n_checks;
    int   n_fail;

    weights_rom dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .data (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the coefficient is (a*37+11) mod 256 viewed as a signed byte.
    function automatic int ref_weight(input int a);
        int v;
        v = (a * 37 + 11) % 256;
        if (v >= 128) v = v - 256;
        return v;
    endfunction

    // Expectation capture: what the register must hold after this edge.
    always @(posedge clk) begin
        if (active) begin
            exp_t e;
            e.addr_tag = int'(addr);
            e.rst_tag  = rst;
            e.exp_val  = rst ? 0 : ref_weight(int'(addr));
            exp_q.push_back(e);
        end
    end

    // Monitor: checks the output mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (int'(data) !== e.exp_val) begin
                n_fail++;
                $display("FAIL data addr=%0d rst=%0b: got %0d, expected %0d",
                         e.addr_tag, e.rst_tag, int'(data), e.exp_val);
            end
        end
    end

    task automatic drive(input logic r, input logic [7:0] a);
        @(negedge clk);
        rst  = r;
        addr = a;
    endtask

    initial begin
        int lim;
        n_checks = 0;
        n_fail   = 0;
        active   = 1'b0;
        rst      = 1'b1;
        addr     = 8'h80;
        active   = 1'b1;

        // Reset held two edges with a non-zero address, then release at addr 0.
        @(negedge clk);
        drive(1'b0, 8'd0);

        // Sequential reads.
        for (int i = 1; i < 4; i++) drive(1'b0, 8'(i));

        // Sign handling.
        drive(1'b0, 8'd4);
        drive(1'b0, 8'd255);
        drive(1'b0, 8'd3);
        drive(1'b0, 8'd6);
        drive(1'b0, 8'd17);

        // Back-to-back sweep with a one-cycle reset at address 100.
        for (int i = 0; i < 256; i++) drive(i == 100, 8'(i));

        // Hold a constant address.
        for (int i = 0; i < 10; i++) drive(1'b0, 8'd7);

        // Random addresses, occasional resets.
        for (int i = 0; i < 400; i++)
            drive(($urandom_range(0, 15) == 0), 8'($urandom_range(0, 255)));

        @(negedge clk);
        active = 1'b0;

        lim = 0;
        while (exp_q.size() > 0 && lim < 5) begin
            @(negedge clk);
            lim++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
